if_id_skid_reg: RTL and testbench

- Pipeline register between the fetch stage and the decode stage.
- Captures each fetched {PC, instruction} beat and presents it to decode under a valid/ready handshake.
- A 2-entry skid buffer absorbs one cycle of decode backpressure without losing a fetched beat.
- Supports a synchronous flush on branch redirect, and keeps stall/flush performance counters.

---
 rtl/if_id_skid_reg_pkg.sv | 25 ++
 rtl/if_id_skid_reg_sat_counter.sv | 30 +++
 rtl/if_id_skid_reg.sv | 122 ++++++++++++
 tb/tb_if_id_skid_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/if_id_skid_reg_pkg.sv
// rtl/if_id_skid_reg_pkg.sv - shared IF/ID pipeline types and constants
//
// Purpose: constants and types shared by the fetch/decode pipeline register
//          and its helpers.
//   NOP_INSTR      instruction presented to decode when no beat is valid
//   if_id_beat_t   one fetched beat {pc, instr}
//   OCC_*          occupancy encoding {main_v, skid_v}

package if_id_skid_reg_pkg;

  localparam int          BEAT_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [BEAT_W-1:0] pc;
    logic [BEAT_W-1:0] instr;
  } if_id_beat_t;

  // Occupancy is the pair {main_v, skid_v}; the skid entry is only ever
  // filled behind a valid main entry, so 2'b01 cannot occur.
  localparam logic [1:0] OCC_EMPTY = 2'b00;
  localparam logic [1:0] OCC_ONE   = 2'b10;
  localparam logic [1:0] OCC_TWO   = 2'b11;

endpackage

// File: rtl/if_id_skid_reg_sat_counter.sv
// rtl/if_id_skid_reg_sat_counter.sv - saturating up-counter
//
// Purpose: counts cycles where inc=1, sticks at all-ones, clears on rst.
// Ports:
//   clk    clock
//   rst    synchronous active-high clear (wins over inc)
//   inc    count this cycle
//   count  current value

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID pipeline register with 2-entry skid buffer
//
// Purpose: holds fetched {pc, instr} beats and presents them to decode under a
//          valid/ready handshake. A skid entry absorbs one beat while decode
//          stalls so if_ready never depends combinationally on id_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_valid/if_pc/if_instr/if_ready   fetch-side handshake
//   id_valid/id_pc/id_instr/id_ready   decode-side handshake
//   flush               drop all held and incoming beats
//   stall_cnt           cycles with id_valid & !id_ready (saturating)
//   flush_cnt           flushes that dropped a valid beat (saturating)

module if_id_skid_reg #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = if_id_skid_reg_pkg::NOP_INSTR,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_instr,
  output logic              if_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instr,
  input  logic              id_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  import if_id_skid_reg_pkg::*;

  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_pc;
  logic [DATA_W-1:0] main_instr;
  logic [DATA_W-1:0] skid_pc;
  logic [DATA_W-1:0] skid_instr;

  logic       accept;
  logic       consume;
  logic [1:0] occ;

  // Ready only looks at the skid flag: with the skid free there is always
  // room for one more beat, whatever decode does this cycle.
  assign if_ready = !skid_v && !rst;
  assign accept   = if_valid && if_ready;
  assign consume  = main_v && id_ready;
  assign occ      = {main_v, skid_v};

  assign id_valid = main_v;
  assign id_pc    = main_pc;
  assign id_instr = main_v ? main_instr : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      main_pc    <= '0;
      main_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only the valid flags drop.
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (accept) begin
            main_v     <= 1'b1;
            main_pc    <= if_pc;
            main_instr <= if_instr;
          end
        end
        OCC_ONE: begin
          if (consume && accept) begin
            main_pc    <= if_pc;
            main_instr <= if_instr;
          end else if (consume) begin
            main_v <= 1'b0;
          end else if (accept) begin
            skid_v     <= 1'b1;
            skid_pc    <= if_pc;
            skid_instr <= if_instr;
          end
        end
        OCC_TWO: begin
          // if_ready is low here, so only the drain path exists.
          if (consume) begin
            main_pc    <= skid_pc;
            main_instr <= skid_instr;
            skid_v     <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding; fall back to empty rather than lock up.
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (main_v && !id_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush && (main_v || skid_v)),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - self-checking bench for if_id_skid_reg

module tb_if_id_skid_reg;

  import if_id_skid_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
  logic        flush;

  logic        if_ready, id_valid;
  logic [31:0] id_pc, id_instr;
  logic [15:0] stall_cnt, flush_cnt;

  logic        if_ready4, id_valid4;
  logic [31:0] id_pc4, id_instr4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  if_id_skid_reg #(.DATA_W(32), .NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_ready(id_ready), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_skid_reg #(.DATA_W(32), .NOP_INSTR(32'h0000_0000), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready4), .id_valid(id_valid4), .id_pc(id_pc4), .id_instr(id_instr4),
    .id_ready(id_ready), .flush(flush), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a FIFO of accepted beats with room for two, plus raw event
  // totals that are clipped to each counter width when compared.
  if_id_beat_t q[$];
  int   stall_total = 0;
  int   flush_total = 0;
  bit   known = 0;

  function automatic logic [63:0] clip(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? 64'(mx) : 64'(v);
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic rd, input logic fl);
    bit          acc, cons;
    if_id_beat_t b;
    rst = r; if_valid = v; if_pc = pc; if_instr = ins; id_ready = rd; flush = fl;
    #1;
    if (known) begin
      check("if_ready", if_ready, !r && (q.size() < 2));
      check("if_ready4", if_ready4, !r && (q.size() < 2));
      check("id_valid", id_valid, q.size() > 0);
      check("id_valid4", id_valid4, q.size() > 0);
      if (q.size() > 0) begin
        check("id_pc", id_pc, q[0].pc);
        check("id_instr", id_instr, q[0].instr);
        check("id_pc4", id_pc4, q[0].pc);
      end else begin
        check("id_instr_nop", id_instr, NOP_INSTR);
      end
      check("stall_cnt", stall_cnt, clip(stall_total, 16));
      check("flush_cnt", flush_cnt, clip(flush_total, 16));
      check("stall_cnt4", stall_cnt4, clip(stall_total, 4));
      check("flush_cnt4", flush_cnt4, clip(flush_total, 4));
    end else if (r) begin
      check("if_ready_in_rst", if_ready, 1'b0);
    end
    acc  = v && !r && (q.size() < 2);
    cons = rd && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      stall_total = 0;
      flush_total = 0;
      known = 1;
    end else begin
      if (q.size() > 0 && !rd) stall_total++;
      if (fl && q.size() > 0) flush_total++;
      if (fl) q.delete();
      else begin
        if (cons) void'(q.pop_front());
        if (acc) begin
          b.pc = pc; b.instr = ins;
          q.push_back(b);
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic rd);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, rd, 1'b0);
  endtask

  initial begin
    // Reset, then confirm reset values of the data path.
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_valid", id_valid, 1'b0);

    // Streaming at full rate.
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);

    // Backpressure fill to TWO, hold, then drain.
    cycle(1'b0, 1'b1, 32'h10, 32'hB000_0010, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h14, 32'hB000_0014, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h18, 32'hB000_0018, 1'b0, 1'b0);
    check("two_if_ready", if_ready, 1'b0);
    check("two_id_pc", id_pc, 32'h10);
    idle(1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Fill to TWO and flush with a beat on the input.
    cycle(1'b0, 1'b1, 32'h30, 32'hC000_0030, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h34, 32'hC000_0034, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h20, 32'hC000_0020, 1'b0, 1'b1);
    check("flush_id_valid", id_valid, 1'b0);
    check("flush_if_ready", if_ready, 1'b1);
    check("flush_cnt_one", flush_cnt, 16'd1);
    idle(1'b1);

    // Flush while empty does not count.
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check("empty_flush_cnt", flush_cnt, 16'd1);
    idle(1'b1);

    // Reset while holding one beat.
    cycle(1'b0, 1'b1, 32'h40, 32'hD000_0040, 1'b0, 1'b0);
    idle(1'b0);
    cycle(1'b1, 1'b1, 32'h44, 32'hD000_0044, 1'b0, 1'b1);
    check("mid_rst_id_valid", id_valid, 1'b0);
    check("mid_rst_stall", stall_cnt, 16'd0);
    idle(1'b1);

    // Long stall saturates the narrow counter.
    cycle(1'b0, 1'b1, 32'h50, 32'hE000_0050, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    check("sat_stall4", stall_cnt4, 4'd15);
    check("sat_stall16", stall_cnt, 16'd20);
    idle(1'b1);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      logic r, v, rd, fl;
      r  = ($urandom_range(0, 249) == 0);
      v  = ($urandom_range(0, 3) != 0);
      rd = (i % 200 < 40) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 24) == 0);
      cycle(r, v, $urandom, $urandom, rd, fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
